// File: rtl/regbank_pkg.sv
// Shared definitions for the 8088 register-bank write path: register codes,
// size/half-select encodings, arbiter state type and the write-request record.
package regbank_pkg;

  localparam logic [3:0] REG_AX    = 4'h0;
  localparam logic [3:0] REG_BX    = 4'h1;
  localparam logic [3:0] REG_CX    = 4'h2;
  localparam logic [3:0] REG_DX    = 4'h3;
  localparam logic [3:0] REG_SP    = 4'h4;
  localparam logic [3:0] REG_BP    = 4'h5;
  localparam logic [3:0] REG_SI    = 4'h6;
  localparam logic [3:0] REG_DI    = 4'h7;
  localparam logic [3:0] REG_IP    = 4'h8;
  localparam logic [3:0] REG_FLAGS = 4'h9;
  localparam logic [3:0] REG_CS    = 4'hA;
  localparam logic [3:0] REG_DS    = 4'hB;
  localparam logic [3:0] REG_SS    = 4'hC;
  localparam logic [3:0] REG_ES    = 4'hD;

  // Highest code the bank implements, and highest code with byte halves.
  localparam logic [3:0] REG_LAST      = REG_ES;
  localparam logic [3:0] REG_LAST_BYTE = REG_DX;

  localparam logic SIZE_8  = 1'b0;
  localparam logic SIZE_16 = 1'b1;
  localparam logic HL_LOW  = 1'b0;
  localparam logic HL_HIGH = 1'b1;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_PAIR2 = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] data;
    logic        size;
    logic        hl;
  } wr_req_t;

  // A write the bank would ignore: unimplemented code, or a byte write to a
  // register that has no addressable halves.
  function automatic logic is_illegal_write(input wr_req_t req);
    return (req.code > REG_LAST) || ((req.size == SIZE_8) && (req.code > REG_LAST_BYTE));
  endfunction

endpackage

// File: rtl/regarb_starve_ctr.sv
// Saturating count of consecutive cycles the BIU has waited while requesting.
// starve_hit flags that the BIU must be granted ahead of the EU.
module regarb_starve_ctr #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic biu_valid,
  input  logic biu_ready,
  output logic starve_hit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] cnt_reg;

  // Count lost BIU cycles (lock cycles included); clear on grant or idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (biu_valid && !biu_ready) begin
      if (cnt_reg != LIMIT) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end else begin
      cnt_reg <= '0;
    end
  end

  assign starve_hit = (cnt_reg == LIMIT);

endmodule

// File: rtl/regbank_write_arbiter.sv
// Arbitrates the single register-bank write port between the EU and the BIU.
// EU has priority unless the BIU has starved; EU pair writes lock the port
// for a second cycle to emit the buffered B write. All wr_* are registered.
// Optional illegal-write check: define REGARB_ILLEGAL_CHK_EN.
module regbank_write_arbiter
  import regbank_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        eu_valid,
  output logic        eu_ready,
  input  logic        eu_pair,
  input  logic [3:0]  eu_reg_a,
  input  logic [15:0] eu_data_a,
  input  logic        eu_size,
  input  logic        eu_hl,
  input  logic [3:0]  eu_reg_b,
  input  logic [15:0] eu_data_b,
  input  logic        biu_valid,
  output logic        biu_ready,
  input  logic [3:0]  biu_reg,
  input  logic [15:0] biu_data,
  output logic        wr_en,
  output logic [3:0]  wr_reg,
  output logic [15:0] wr_data,
  output logic        wr_size,
  output logic        wr_hl,
  output logic        busy
`ifdef REGARB_ILLEGAL_CHK_EN
  ,
  output logic        err_illegal
`endif
);

  arb_state_t  state_reg, state_next;
  wr_req_t     out_reg, req_next;
  logic        wr_en_reg;
  logic        fire;
  logic        capture_b;
  logic [3:0]  b_code_reg;
  logic [15:0] b_data_reg;
  logic        starve_hit;

  regarb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .biu_valid  (biu_valid),
    .biu_ready  (biu_ready),
    .starve_hit (starve_hit)
  );

  // Grant, next write record and next state; request fields pass straight
  // into the output record so the bank sees them one edge after acceptance.
  always_comb begin
    eu_ready   = 1'b0;
    biu_ready  = 1'b0;
    fire       = 1'b0;
    capture_b  = 1'b0;
    req_next   = out_reg;
    state_next = state_reg;
    case (state_reg)
      S_RUN: begin
        if (starve_hit && biu_valid) begin
          biu_ready = 1'b1;
        end else if (eu_valid) begin
          eu_ready = 1'b1;
        end else if (biu_valid) begin
          biu_ready = 1'b1;
        end

        if (biu_ready) begin
          fire     = 1'b1;
          req_next = '{code: biu_reg, data: biu_data, size: SIZE_16, hl: HL_LOW};
        end else if (eu_ready) begin
          fire     = 1'b1;
          req_next = '{code: eu_reg_a, data: eu_data_a, size: eu_size,
                       hl: (eu_size ? HL_LOW : eu_hl)};
          if (eu_pair) begin
            capture_b  = 1'b1;
            state_next = S_PAIR2;
          end
        end
      end
      S_PAIR2: begin
        fire       = 1'b1;
        req_next   = '{code: b_code_reg, data: b_data_reg, size: SIZE_16, hl: HL_LOW};
        state_next = S_RUN;
      end
      default: begin
        state_next = S_RUN;
      end
    endcase
  end

  // State register and pair-B buffer; reset discards any pending B write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= S_RUN;
      b_code_reg <= '0;
      b_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (capture_b) begin
        b_code_reg <= eu_reg_b;
        b_data_reg <= eu_data_b;
      end
    end
  end

`ifdef REGARB_ILLEGAL_CHK_EN
  logic err_reg;
  logic illegal;

  assign illegal = is_illegal_write(req_next);

  // Registered bank write port; illegal writes are flagged and suppressed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_reg   <= '0;
      wr_en_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      out_reg   <= req_next;
      wr_en_reg <= fire && !illegal;
      err_reg   <= fire && illegal;
    end
  end

  assign err_illegal = err_reg;
`else
  // Registered bank write port; every accepted write is forwarded as issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_reg   <= '0;
      wr_en_reg <= 1'b0;
    end else begin
      out_reg   <= req_next;
      wr_en_reg <= fire;
    end
  end
`endif

  assign wr_en   = wr_en_reg;
  assign wr_reg  = out_reg.code;
  assign wr_data = out_reg.data;
  assign wr_size = out_reg.size;
  assign wr_hl   = out_reg.hl;
  assign busy    = (state_reg == S_PAIR2);

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Self-checking bench for regbank_write_arbiter: directed scenarios plus a
// randomized run, all scored against a cycle-level behavioural model.
module tb_regbank_write_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        eu_valid, eu_ready, eu_pair, eu_size, eu_hl;
  logic [3:0]  eu_reg_a, eu_reg_b;
  logic [15:0] eu_data_a, eu_data_b;
  logic        biu_valid, biu_ready;
  logic [3:0]  biu_reg;
  logic [15:0] biu_data;
  logic        wr_en, wr_size, wr_hl, busy;
  logic [3:0]  wr_reg;
  logic [15:0] wr_data;
`ifdef REGARB_ILLEGAL_CHK_EN
  logic        err_illegal;
`endif

  regbank_write_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .eu_valid(eu_valid), .eu_ready(eu_ready), .eu_pair(eu_pair),
    .eu_reg_a(eu_reg_a), .eu_data_a(eu_data_a), .eu_size(eu_size), .eu_hl(eu_hl),
    .eu_reg_b(eu_reg_b), .eu_data_b(eu_data_b),
    .biu_valid(biu_valid), .biu_ready(biu_ready), .biu_reg(biu_reg), .biu_data(biu_data),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .wr_size(wr_size), .wr_hl(wr_hl),
    .busy(busy)
`ifdef REGARB_ILLEGAL_CHK_EN
    , .err_illegal(err_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] data;
    logic        size;
    logic        hl;
  } tb_wr_t;

  int checks = 0;
  int passes = 0;

  // Behavioural model: lock flag for a pending B write, lost-cycle tally,
  // last write presented on the port.
  logic   m_lock;
  tb_wr_t m_b;
  int     m_lost;
  tb_wr_t m_last;
  logic   g_eu, g_biu;

  task automatic model_reset();
    m_lock = 1'b0;
    m_b    = '{4'h0, 16'h0, 1'b0, 1'b0};
    m_lost = 0;
    m_last = '{4'h0, 16'h0, 1'b0, 1'b0};
    g_eu   = 1'b0;
    g_biu  = 1'b0;
  endtask

  task automatic idle_inputs();
    eu_valid = 0; eu_pair = 0; eu_reg_a = 0; eu_data_a = 0; eu_size = 0; eu_hl = 0;
    eu_reg_b = 0; eu_data_b = 0; biu_valid = 0; biu_reg = 0; biu_data = 0;
  endtask

  // One clock of scoreboarding: called with inputs already applied (just
  // after a rising edge); returns #1 after the next rising edge.
  task automatic do_cycle(input string tag);
    tb_wr_t w;
    logic   have, illegal, exp_en, exp_err;
    @(negedge clk);
    g_eu  = 1'b0;
    g_biu = 1'b0;
    if (!m_lock) begin
      if (biu_valid && m_lost >= STARVE_LIMIT) g_biu = 1'b1;
      else if (eu_valid)                       g_eu  = 1'b1;
      else if (biu_valid)                      g_biu = 1'b1;
    end
    checks++;
    if (eu_ready !== g_eu) $display("FAIL %s eu_ready got=%b want=%b", tag, eu_ready, g_eu);
    else passes++;
    checks++;
    if (biu_ready !== g_biu) $display("FAIL %s biu_ready got=%b want=%b", tag, biu_ready, g_biu);
    else passes++;

    have = 1'b1;
    w = m_last;
    if (m_lock) begin
      w = m_b;
      m_lock = 1'b0;
    end else if (g_biu) begin
      w = '{biu_reg, biu_data, 1'b1, 1'b0};
    end else if (g_eu) begin
      w = '{eu_reg_a, eu_data_a, eu_size, (eu_size ? 1'b0 : eu_hl)};
      if (eu_pair) begin
        m_lock = 1'b1;
        m_b = '{eu_reg_b, eu_data_b, 1'b1, 1'b0};
      end
    end else begin
      have = 1'b0;
    end
    if (biu_valid && !g_biu) m_lost = (m_lost + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_lost + 1;
    else m_lost = 0;
    m_last  = w;
    illegal = have && ((w.code > 4'hD) || (!w.size && w.code > 4'h3));
`ifdef REGARB_ILLEGAL_CHK_EN
    exp_en  = have && !illegal;
    exp_err = illegal;
`else
    exp_en  = have;
    exp_err = 1'b0;
`endif

    @(posedge clk);
    #1;
    checks++;
    if (wr_en !== exp_en || wr_reg !== w.code || wr_data !== w.data ||
        wr_size !== w.size || wr_hl !== w.hl || busy !== m_lock)
      $display("FAIL %s port got=en%b r%h d%h s%b h%b b%b want=en%b r%h d%h s%b h%b b%b",
               tag, wr_en, wr_reg, wr_data, wr_size, wr_hl, busy,
               exp_en, w.code, w.data, w.size, w.hl, m_lock);
    else passes++;
`ifdef REGARB_ILLEGAL_CHK_EN
    checks++;
    if (err_illegal !== exp_err) $display("FAIL %s err_illegal got=%b want=%b", tag, err_illegal, exp_err);
    else passes++;
`else
    if (exp_err) $display("unexpected illegal flag in model for %s", tag);
`endif
    $display("cyc %s: eu_rdy=%b biu_rdy=%b wr_en=%b reg=%h data=%h size=%b hl=%b busy=%b",
             tag, g_eu, g_biu, wr_en, wr_reg, wr_data, wr_size, wr_hl, busy);
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    eu_valid = 1; eu_reg_a = 4'h3; eu_data_a = 16'h5A5A; eu_size = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_en !== 0 || wr_reg !== 0 || wr_data !== 0 || wr_size !== 0 || wr_hl !== 0 || busy !== 0)
      $display("FAIL reset_state got=en%b r%h d%h s%b h%b b%b want=all zero",
               wr_en, wr_reg, wr_data, wr_size, wr_hl, busy);
    else passes++;
    reset = 1'b1;
    model_reset();
    do_cycle("reset_release");
    checks++;
    if (wr_en !== 1 || wr_data !== 16'h5A5A)
      $display("FAIL first_after_reset got=en%b d%h want=en1 d5a5a", wr_en, wr_data);
    else passes++;
    idle_inputs();
    do_cycle("reset_idle");
  endtask

  task automatic test_eu_single_8bit();
    idle_inputs();
    eu_valid = 1; eu_reg_a = 4'h2; eu_data_a = 16'h00A5; eu_size = 0; eu_hl = 1;
    do_cycle("eu8");
    checks++;
    if (wr_en !== 1 || wr_reg !== 4'h2 || wr_data !== 16'h00A5 || wr_size !== 0 || wr_hl !== 1)
      $display("FAIL eu8_write got=en%b r%h d%h s%b h%b want=en1 r2 d00a5 s0 h1",
               wr_en, wr_reg, wr_data, wr_size, wr_hl);
    else passes++;
    idle_inputs();
    do_cycle("eu8_idle");
    checks++;
    if (wr_en !== 0 || wr_reg !== 4'h2 || wr_data !== 16'h00A5)
      $display("FAIL hold_after_write got=en%b r%h d%h want=en0 r2 d00a5", wr_en, wr_reg, wr_data);
    else passes++;
  endtask

  task automatic test_pair();
    idle_inputs();
    eu_valid = 1; eu_pair = 1; eu_reg_a = 4'h0; eu_data_a = 16'h1234; eu_size = 1;
    eu_reg_b = 4'h1; eu_data_b = 16'hBEEF;
    biu_valid = 1; biu_reg = 4'hA; biu_data = 16'hF000;
    do_cycle("pair_a");
    checks++;
    if (wr_reg !== 4'h0 || wr_data !== 16'h1234 || busy !== 1)
      $display("FAIL pair_a got=r%h d%h busy%b want=r0 d1234 busy1", wr_reg, wr_data, busy);
    else passes++;
    eu_valid = 0; eu_pair = 0;
    #1;
    checks++;
    if (biu_ready !== 0 || eu_ready !== 0)
      $display("FAIL pair_lock_ready got=biu%b eu%b want=0 0", biu_ready, eu_ready);
    else passes++;
    do_cycle("pair_b");
    checks++;
    if (wr_en !== 1 || wr_reg !== 4'h1 || wr_data !== 16'hBEEF || wr_size !== 1 || wr_hl !== 0 || busy !== 0)
      $display("FAIL pair_b got=en%b r%h d%h s%b h%b busy%b want=en1 r1 dbeef s1 h0 busy0",
               wr_en, wr_reg, wr_data, wr_size, wr_hl, busy);
    else passes++;
    do_cycle("pair_biu");
    checks++;
    if (wr_en !== 1 || wr_reg !== 4'hA || wr_data !== 16'hF000)
      $display("FAIL pair_then_biu got=en%b r%h d%h want=en1 ra df000", wr_en, wr_reg, wr_data);
    else passes++;
    idle_inputs();
    do_cycle("pair_idle");
  endtask

  task automatic test_starvation();
    int eu_wins;
    idle_inputs();
    do_cycle("starve_pre");
    eu_valid = 1; eu_reg_a = 4'h6; eu_data_a = 16'h0042; eu_size = 1;
    biu_valid = 1; biu_reg = 4'h8; biu_data = 16'h0100;
    eu_wins = 0;
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      do_cycle("starve_eu");
      if (g_eu) eu_wins++;
    end
    checks++;
    if (eu_wins != STARVE_LIMIT)
      $display("FAIL starve_eu_grants got=%0d want=%0d", eu_wins, STARVE_LIMIT);
    else passes++;
    #1;
    checks++;
    if (biu_ready !== 1 || eu_ready !== 0)
      $display("FAIL starve_promote got=biu%b eu%b want=biu1 eu0", biu_ready, eu_ready);
    else passes++;
    do_cycle("starve_biu");
    checks++;
    if (wr_en !== 1 || wr_reg !== 4'h8 || wr_data !== 16'h0100 || wr_size !== 1)
      $display("FAIL starve_biu_write got=en%b r%h d%h s%b want=en1 r8 d0100 s1",
               wr_en, wr_reg, wr_data, wr_size);
    else passes++;
    #1;
    checks++;
    if (eu_ready !== 1 || biu_ready !== 0)
      $display("FAIL starve_cleared got=eu%b biu%b want=eu1 biu0", eu_ready, biu_ready);
    else passes++;
    do_cycle("starve_after");
    idle_inputs();
    do_cycle("starve_idle");
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    do_cycle("simul_pre");
    eu_valid = 1; eu_reg_a = 4'h7; eu_data_a = 16'hCAFE; eu_size = 1; eu_hl = 1;
    biu_valid = 1; biu_reg = 4'hB; biu_data = 16'h1111;
    #1;
    checks++;
    if (eu_ready !== 1 || biu_ready !== 0)
      $display("FAIL simul_grant got=eu%b biu%b want=eu1 biu0", eu_ready, biu_ready);
    else passes++;
    do_cycle("simul");
    checks++;
    if (wr_reg !== 4'h7 || wr_data !== 16'hCAFE || wr_hl !== 0)
      $display("FAIL simul_write got=r%h d%h h%b want=r7 dcafe h0", wr_reg, wr_data, wr_hl);
    else passes++;
    eu_valid = 0;
    do_cycle("simul_biu");
    idle_inputs();
    do_cycle("simul_idle");
  endtask

  task automatic test_illegal();
    idle_inputs();
    eu_valid = 1; eu_reg_a = 4'h5; eu_data_a = 16'h0077; eu_size = 0; eu_hl = 0;
    #1;
    checks++;
    if (eu_ready !== 1) $display("FAIL illegal_handshake got=%b want=1", eu_ready);
    else passes++;
    do_cycle("illegal");
`ifdef REGARB_ILLEGAL_CHK_EN
    checks++;
    if (wr_en !== 0 || err_illegal !== 1)
      $display("FAIL illegal_suppress got=en%b err%b want=en0 err1", wr_en, err_illegal);
    else passes++;
`else
    checks++;
    if (wr_en !== 1 || wr_reg !== 4'h5)
      $display("FAIL illegal_forward got=en%b r%h want=en1 r5", wr_en, wr_reg);
    else passes++;
`endif
    idle_inputs();
    do_cycle("illegal_idle");
  endtask

  task automatic test_reset_mid_pair();
    idle_inputs();
    eu_valid = 1; eu_pair = 1; eu_reg_a = 4'h2; eu_data_a = 16'h2222; eu_size = 1;
    eu_reg_b = 4'h3; eu_data_b = 16'h3333;
    do_cycle("midpair_a");
    idle_inputs();
    #1 reset = 1'b0;
    #1;
    checks++;
    if (wr_en !== 0 || busy !== 0 || wr_reg !== 0 || wr_data !== 0)
      $display("FAIL midpair_reset got=en%b busy%b r%h d%h want=0 0 0 0", wr_en, busy, wr_reg, wr_data);
    else passes++;
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    do_cycle("midpair_release");
    checks++;
    if (wr_en !== 0 || wr_data === 16'h3333)
      $display("FAIL midpair_discard got=en%b d%h want=en0 no B", wr_en, wr_data);
    else passes++;
  endtask

  task automatic test_random();
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      if (!(eu_valid && !g_eu)) begin
        eu_valid  = ($urandom_range(0, 99) < 55);
        eu_pair   = ($urandom_range(0, 99) < 30);
        eu_reg_a  = 4'($urandom_range(0, 15));
        eu_data_a = 16'($urandom);
        eu_size   = 1'($urandom);
        eu_hl     = 1'($urandom);
        eu_reg_b  = 4'($urandom_range(0, 15));
        eu_data_b = 16'($urandom);
      end
      if (!(biu_valid && !g_biu)) begin
        biu_valid = ($urandom_range(0, 99) < 50);
        biu_reg   = 4'($urandom_range(0, 15));
        biu_data  = 16'($urandom);
      end
      do_cycle("rand");
    end
    idle_inputs();
    do_cycle("rand_idle");
    do_cycle("rand_idle");
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();
    test_reset();
    test_eu_single_8bit();
    test_pair();
    test_starvation();
    test_simultaneous();
    test_illegal();
    test_reset_mid_pair();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
